// File: rtl/aes_usb_pkg.sv
// Shared definitions for the AES <-> USB byte/block datapath.
// Holds the block geometry and byte-order helpers used by both the
// byte-to-block extractor and the block-to-byte inserter.
package aes_usb_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BYTE_W      = 8;
  localparam int BLOCK_W     = BLOCK_BYTES * BYTE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } insert_state_t;

  // Byte n of a block lives at the MSB end: byte 0 = blk[BLOCK_W-1 -: BYTE_W].
  function automatic logic [BYTE_W-1:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                                    input int unsigned n);
    block_byte = blk[BLOCK_W-1-n*BYTE_W -: BYTE_W];
  endfunction

endpackage

// File: rtl/block_shift_reg.sv
// Block-wide shift register: parallel load, shift left by one byte, zero fill.
// Ports: clk/n_rst (async active-low), clr_i (sync clear), load_i + data_i
// (parallel load), shift_i (shift one byte), top_byte_o (current MSB byte).
module block_shift_reg #(
  parameter  int NUM_BYTES = 16,
  parameter  int DATA_W    = 8,
  localparam int BLK_W     = NUM_BYTES * DATA_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [BLK_W-1:0]  data_i,
  output logic [DATA_W-1:0] top_byte_o
);

  logic [BLK_W-1:0] shreg_q, shreg_d;

  // Clear wins over load, load wins over shift.
  always_comb begin
    shreg_d = shreg_q;
    if (clr_i) begin
      shreg_d = '0;
    end else if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[BLK_W-DATA_W-1:0], {DATA_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign top_byte_o = shreg_q[BLK_W-1 -: DATA_W];

endmodule

// File: rtl/insert_fifo.sv
// Serializes one 128-bit ciphertext block MSB byte first into the outbound byte FIFO.
// Ports: clk/n_rst, clear (sync flush), block_valid/block_in/block_ready (block
// handshake), fifo_full/push/data_out (FIFO write side), busy, done (1-cycle pulse).
module insert_fifo
  import aes_usb_pkg::*;
#(
  parameter  int NUM_BYTES = BLOCK_BYTES,
  parameter  int DATA_W    = BYTE_W,
  localparam int BLK_W     = NUM_BYTES * DATA_W,
  localparam int CNT_W     = $clog2(NUM_BYTES)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              block_valid,
  input  logic [BLK_W-1:0]  block_in,
  output logic              block_ready,
  input  logic              fifo_full,
  output logic              push,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  insert_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, shift;

  block_shift_reg #(
    .NUM_BYTES (NUM_BYTES),
    .DATA_W    (DATA_W)
  ) u_shreg (
    .clk        (clk),
    .n_rst      (n_rst),
    .clr_i      (clear),
    .load_i     (load),
    .shift_i    (shift),
    .data_i     (block_in),
    .top_byte_o (data_out)
  );

  // Zero-cycle response to fifo_full and clear; everything else is registered.
  assign push        = (state_q == SEND) && !fifo_full && !clear;
  assign block_ready = (state_q == IDLE);
  assign busy        = (state_q == SEND);
  assign done        = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    if (clear) begin
      // Flush dominates; the shift register clears itself on the same input.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (block_valid) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (push) begin
            shift = 1'b1;
            if (cnt_q == CNT_W'(NUM_BYTES - 1)) begin
              cnt_d   = '0;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_insert_fifo.sv
// Bench for insert_fifo: directed scenarios plus random traffic, checked
// against a byte-queue reference model sampled on the falling clock edge.
module tb_insert_fifo;
  import aes_usb_pkg::*;

  localparam int NB = BLOCK_BYTES;
  localparam int DW = BYTE_W;
  localparam int BW = NB * DW;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          clear = 1'b0;
  logic          block_valid = 1'b0;
  logic [BW-1:0] block_in = '0;
  logic          fifo_full = 1'b0;
  logic          block_ready, push, busy, done;
  logic [DW-1:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bytes still owed for the current block, plus a pending done pulse.
  logic [DW-1:0] exp_q[$];
  bit            done_pend = 1'b0;

  always #5 clk = ~clk;

  insert_fifo dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (clear),
    .block_valid (block_valid),
    .block_in    (block_in),
    .block_ready (block_ready),
    .fifo_full   (fifo_full),
    .push        (push),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_block_ready"}, 32'(block_ready), 32'd1);
    chk({tag, "_push"},        32'(push),        32'd0);
    chk({tag, "_data_out"},    32'(data_out),    32'd0);
    chk({tag, "_busy"},        32'(busy),        32'd0);
    chk({tag, "_done"},        32'(done),        32'd0);
  endtask

  // Monitor + model: compare every cycle, then advance the model by one cycle.
  always @(negedge clk) begin
    logic          exp_push;
    logic [DW-1:0] exp_dat;
    logic [BW-1:0] blk;
    if (!n_rst) begin
      exp_q.delete();
      done_pend = 1'b0;
      chk_reset_outputs("rst");
    end else begin
      exp_push = (exp_q.size() != 0) && !fifo_full && !clear;
      exp_dat  = (exp_q.size() != 0) ? exp_q[0] : '0;
      chk("block_ready", 32'(block_ready), 32'((exp_q.size() == 0) && !done_pend));
      chk("busy",        32'(busy),        32'(exp_q.size() != 0));
      chk("done",        32'(done),        32'(done_pend));
      chk("push",        32'(push),        32'(exp_push));
      chk("data_out",    32'(data_out),    32'(exp_dat));
      if (clear) begin
        exp_q.delete();
        done_pend = 1'b0;
      end else if (done_pend) begin
        done_pend = 1'b0;
      end else if (exp_q.size() != 0) begin
        if (exp_push) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) done_pend = 1'b1;
        end
      end else if (block_valid) begin
        blk = block_in;
        for (int i = 0; i < NB; i++) exp_q.push_back(blk[BW-1-i*DW -: DW]);
      end
    end
  end

  function automatic logic [BW-1:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [BW-1:0] ramp_blk;
  int            n_push;

  initial begin
    for (int i = 0; i < NB; i++) ramp_blk[BW-1-i*DW -: DW] = DW'(i);

    // Reset held for a few cycles (monitor checks reset values each cycle).
    ticks(3);
    n_rst = 1'b1;
    ticks(2);

    // Unstalled ramp block; block_in scrambled after acceptance.
    block_valid = 1'b1;
    block_in    = ramp_blk;
    tick();
    block_valid = 1'b0;
    block_in    = rand_blk();
    n_push = 0;
    for (int i = 0; i < NB; i++) begin
      if (push) n_push++;
      tick();
    end
    chk("ramp_push_count", 32'(n_push), 32'(NB));
    chk("ramp_done_slot",  32'(done), 32'd1);
    tick();
    chk("ramp_ready_back", 32'(block_ready), 32'd1);
    ticks(2);

    // Same block with fifo_full high three cycles after two bytes go out.
    block_valid = 1'b1;
    block_in    = ramp_blk;
    tick();
    block_valid = 1'b0;
    ticks(2);
    fifo_full = 1'b1;
    chk("stall_data_held", 32'(data_out), 32'h02);
    ticks(3);
    fifo_full = 1'b0;
    chk("stall_resume_data", 32'(data_out), 32'h02);
    ticks(14);
    chk("stall_done_slot", 32'(done), 32'd1);
    ticks(3);

    // Clear while byte 7 is presented, then an all-ones block.
    block_valid = 1'b1;
    block_in    = ramp_blk;
    tick();
    block_valid = 1'b0;
    ticks(7);
    chk("clear_byte7_seen", 32'(data_out), 32'h07);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_back_idle", 32'(block_ready), 32'd1);
    ticks(3);
    block_valid = 1'b1;
    block_in    = '1;
    tick();
    block_valid = 1'b0;
    ticks(20);

    // block_valid held across two blocks; second appears while first is sending.
    block_valid = 1'b1;
    block_in    = rand_blk();
    tick();
    block_in    = rand_blk();
    ticks(22);
    block_valid = 1'b0;
    block_in    = rand_blk();
    ticks(20);

    // Asynchronous reset while byte 9 is presented.
    block_valid = 1'b1;
    block_in    = ramp_blk;
    tick();
    block_valid = 1'b0;
    ticks(9);
    chk("pre_rst_byte9", 32'(data_out), 32'h09);
    #2;
    n_rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    tick();
    n_rst = 1'b1;
    tick();
    block_valid = 1'b1;
    block_in    = rand_blk();
    tick();
    block_valid = 1'b0;
    ticks(20);

    // Random traffic: valid, data, back-pressure and occasional flush.
    for (int c = 0; c < 600; c++) begin
      block_valid = 1'($urandom_range(0, 1));
      block_in    = rand_blk();
      fifo_full   = ($urandom_range(0, 9) < 3);
      clear       = ($urandom_range(0, 59) == 0);
      tick();
    end
    block_valid = 1'b0;
    fifo_full   = 1'b0;
    clear       = 1'b0;
    ticks(25);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/insert_fifo.md
# insert_fifo

Downstream companion to the byte-to-block extractor: takes one 128-bit block from the AES core (ciphertext) and serializes it MSB byte first into the outbound byte FIFO feeding the USB transmit path. Sits between the AES core output register and the outbound data FIFO. It honours FIFO back-pressure, supports a synchronous flush, and signals completion so the controller can release the next block.

## Interface
- NUM_BYTES, 16, bytes per block; counter width = $clog2(NUM_BYTES)
- DATA_W, 8, FIFO word width; block width BLK_W = NUM_BYTES*DATA_W (128)
- clk  input  1  clock; all state updates on rising edge
- n_rst  input  1  reset, asynchronous, active-low
- clear  input  1  synchronous flush; abandons current block
- block_valid  input  1  block_in holds a block to send
- block_in  input  BLK_W  block, byte 0 = block_in[BLK_W-1 -: DATA_W]
- block_ready  output  1  block accepted this cycle if block_valid also high
- fifo_full  input  1  outbound FIFO cannot accept a write this cycle
- push  output  1  write strobe to outbound FIFO
- data_out  output  DATA_W  byte presented with push
- busy  output  1  block held, not all bytes pushed
- done  output  1  one-cycle pulse after final byte pushed

## Operation
- Reset values: block_ready 1, push 0, data_out 0, busy 0, done 0; state IDLE, shift register 0, byte count 0.
- States: IDLE, SEND, DONE.
- IDLE: block_ready=1. On block_valid & !clear: load shift register with block_in, count<=0, go SEND.
- SEND: block_ready=0, busy=1. push = !fifo_full & !clear (combinational); data_out = shift register top byte (always driven, even while stalled).
- On push: shift register shifts left DATA_W, zero fill; count<=count+1. Push with count==NUM_BYTES-1 -> DONE.
- fifo_full high in SEND: push=0, register and count held; no byte dropped or duplicated; resume on first cycle fifo_full low.
- DONE: done=1, busy=0, block_ready=0, push=0; unconditionally -> IDLE next cycle.
- clear (any state): next state IDLE, count 0, shift register 0; no push, no done that cycle. clear dominates block_valid and fifo_full.
- Block ordering: bytes emitted block_in[127:120] first, block_in[7:0] last, inverse of extractor packing.
- block_in sampled only at acceptance edge; later changes ignored.
- n_rst mid-block: immediate return to reset values; bytes already pushed stay in FIFO (controller flushes FIFO).

## Timing
- Acceptance edge k (IDLE, block_valid=1). First push cycle k+1 earliest.
- No back-pressure: pushes in cycles k+1..k+16, done in k+17, block_ready high again k+18.
- Throughput: one block per NUM_BYTES+2 cycles unstalled; each fifo_full cycle in SEND adds one cycle.
- push, data_out combinational from registered state/fifo_full/clear; all other outputs derived from registered state.
- fifo_full to push: zero-cycle response (same cycle).

## Structure
- Shared package aes_usb_pkg: insert_state_t enum {IDLE, SEND, DONE}, BLOCK_BYTES=16, BYTE_W=8; extractor and this block share the byte-order constants.
- One sub-module: block_shift_reg (parallel load, shift-left-by-DATA_W enable, sync clear, async reset), instanced once; counter and FSM stay in insert_fifo.

## Test plan
- Reset: hold n_rst low -> block_ready=1, push=0, data_out=0, busy=0, done=0.
- Block 128'h000102...0F, fifo_full=0 -> push high 16 cycles, data_out 00,01,...,0F, done pulse cycle 17, block_ready high cycle 18.
- Same block, fifo_full high cycles 3-5 after acceptance -> push low those cycles, data_out held at 02, sequence complete and unduplicated, done at cycle 20.
- clear asserted during byte 7 -> no push that cycle, returns IDLE, no done; next block 128'hFF..FF sends 16×FF.
- block_valid held high with two different blocks back to back -> second accepted only after done cycle; block_in changes during SEND do not alter emitted bytes.
- n_rst pulsed mid-SEND at byte 9 -> outputs return to reset values asynchronously; new block after reset sent from byte 0.
